// File: rtl/rf_done_aggregator.sv
`default_nettype none
// ============================================================================
// Module      : rf_done_aggregator
// Description : Waits for every masked completion channel, with optional
//               timeout. Define RF_DONE_AGG_STICKY_EN for sticky ch_done capture.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_done_aggregator #(
    parameter int NUM_CH    = 11,
    parameter int TIMEOUT_W = 20,
    parameter int POLL_DIV  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_CH-1:0]    ch_mask,
    input  logic [NUM_CH-1:0]    ch_done,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    output logic                 busy,
    output logic                 done,
    output logic                 timed_out,
    output logic                 pass,
    output logic [NUM_CH-1:0]    ch_status,
    output logic [TIMEOUT_W-1:0] elapsed
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_wait   = 2'd1;
    localparam logic [1:0] c_st_fin_ok = 2'd2;
    localparam logic [1:0] c_st_fin_to = 2'd3;
    localparam logic [7:0] c_poll_last = 8'(POLL_DIV - 1);

    logic [1:0]           r_state;
    logic [NUM_CH-1:0]    r_mask;
    logic [TIMEOUT_W-1:0] r_timeout;
    logic [7:0]           r_poll;
    logic [NUM_CH-1:0]    w_complete;
    logic                 w_eval;
    logic                 w_all_done;
    logic                 w_expire;
    logic [TIMEOUT_W:0]   w_elapsed_nxt;

`ifdef RF_DONE_AGG_STICKY_EN
    logic [NUM_CH-1:0] r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (r_state == c_st_idle && start) begin
            r_acc <= '0;
        end else if (r_state == c_st_wait) begin
            r_acc <= r_acc | ch_done;
        end
    end

    // Include the live flags so a channel finishing this cycle already counts.
    assign w_complete = r_acc | ch_done;
`else
    assign w_complete = ch_done;
`endif

    assign w_eval        = (r_poll == c_poll_last);
    assign w_all_done    = w_eval && ((w_complete & r_mask) == r_mask);
    assign w_elapsed_nxt = {1'b0, elapsed} + {{TIMEOUT_W{1'b0}}, 1'b1};
    assign w_expire      = (r_timeout != '0) && (w_elapsed_nxt >= {1'b0, r_timeout});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_mask    <= '0;
            r_timeout <= '0;
            r_poll    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timed_out <= 1'b0;
            pass      <= 1'b0;
            ch_status <= '0;
            elapsed   <= '0;
        end else begin
            done      <= 1'b0;
            timed_out <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_mask    <= ch_mask;
                        r_timeout <= timeout_cycles;
                        r_poll    <= '0;
                        elapsed   <= '0;
                        pass      <= 1'b0;
                        ch_status <= '0;
                        busy      <= 1'b1;
                        r_state   <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (!(&elapsed)) begin
                        elapsed <= w_elapsed_nxt[TIMEOUT_W-1:0];
                    end
                    r_poll <= w_eval ? 8'd0 : r_poll + 8'd1;
                    // Completion takes priority over a simultaneous expiry.
                    if (w_all_done) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b1;
                        ch_status <= w_complete;
                        r_state   <= c_st_fin_ok;
                    end else if (w_expire) begin
                        busy      <= 1'b0;
                        timed_out <= 1'b1;
                        ch_status <= w_complete;
                        r_state   <= c_st_fin_to;
                    end
                end
                c_st_fin_ok,
                c_st_fin_to: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_done_aggregator.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_done_aggregator
// Description : Drives two aggregators (POLL_DIV 1 and 4) with shared stimulus
//               and checks both against an outcome model of the wait rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_done_aggregator;

`ifdef RF_DONE_AGG_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] ch_mask;
    logic [3:0] ch_done;
    logic [7:0] timeout_cycles;

    logic       busy1, done1, to1, pass1;
    logic [3:0] st1;
    logic [7:0] el1;
    logic       busy4, done4, to4, pass4;
    logic [3:0] st4;
    logic [7:0] el4;

    always #5 clk = ~clk;

    rf_done_aggregator #(.NUM_CH(4), .TIMEOUT_W(8), .POLL_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .ch_done(ch_done),
        .timeout_cycles(timeout_cycles), .busy(busy1), .done(done1), .timed_out(to1),
        .pass(pass1), .ch_status(st1), .elapsed(el1)
    );

    rf_done_aggregator #(.NUM_CH(4), .TIMEOUT_W(8), .POLL_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .ch_done(ch_done),
        .timeout_cycles(timeout_cycles), .busy(busy4), .done(done4), .timed_out(to4),
        .pass(pass4), .ch_status(st4), .elapsed(el4)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] seq [0:399];
    int         exp_kind [2];
    int         exp_at   [2];
    logic [3:0] exp_st   [2];
    int         fin      [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Outcome of one wait: kind 1 = done, 2 = timeout; 'at' is the WAIT-cycle
    // index on which the pulse is visible (elapsed equals it then).
    function automatic void model(input logic [3:0] m, input int t, input int pd,
                                  output int kind, output int at, output logic [3:0] st);
        logic [3:0] seen;
        logic [3:0] comp;
        seen = 4'h0;
        kind = 0;
        at   = -1;
        st   = 4'h0;
        for (int c = 0; c < 400; c++) begin
            seen = seen | seq[c];
            comp = STICKY ? seen : seq[c];
            if (((c + 1) % pd == 0) && ((comp & m) == m)) begin
                kind = 1; at = c + 1; st = comp; return;
            end
            if (t != 0 && c + 1 >= t) begin
                kind = 2; at = c + 1; st = comp; return;
            end
        end
    endfunction

    task automatic step(input int id, input int cyc, input logic b, input logic d,
                        input logic to, input logic p, input logic [3:0] s,
                        input logic [7:0] e);
        string nm;
        nm = (id == 0) ? "pd1" : "pd4";
        if (fin[id] == 0) begin
            if (cyc == exp_at[id] || d || to) begin
                chk({nm, "_event_cycle"}, cyc, exp_at[id]);
                chk({nm, "_done"}, d, exp_kind[id] == 1);
                chk({nm, "_timed_out"}, to, exp_kind[id] == 2);
                chk({nm, "_pass"}, p, exp_kind[id] == 1);
                chk({nm, "_ch_status"}, s, exp_st[id]);
                chk({nm, "_elapsed_end"}, e, exp_at[id]);
                chk({nm, "_busy_end"}, b, 0);
                fin[id] = 1;
            end else begin
                chk({nm, "_busy_wait"}, b, 1);
                chk({nm, "_elapsed_wait"}, e, cyc);
                chk({nm, "_pass_wait"}, p, 0);
            end
        end else if (fin[id] == 1) begin
            chk({nm, "_pulse_clear"}, {d, to}, 0);
            chk({nm, "_busy_idle"}, b, 0);
            chk({nm, "_pass_hold"}, p, exp_kind[id] == 1);
            chk({nm, "_elapsed_hold"}, e, exp_at[id]);
            fin[id] = 2;
        end
    endtask

    task automatic run(input logic [3:0] m, input int t, input int mid_start);
        int cyc;
        model(m, t, 1, exp_kind[0], exp_at[0], exp_st[0]);
        model(m, t, 4, exp_kind[1], exp_at[1], exp_st[1]);
        fin[0] = 0;
        fin[1] = 0;
        start          = 1'b1;
        ch_mask        = m;
        timeout_cycles = 8'(t);
        @(posedge clk); #1;
        start          = 1'b0;
        ch_mask        = 4'($urandom);
        timeout_cycles = 8'($urandom);
        cyc = 0;
        while (1) begin
            step(0, cyc, busy1, done1, to1, pass1, st1, el1);
            step(1, cyc, busy4, done4, to4, pass4, st4, el4);
            if (fin[0] == 2 && fin[1] == 2) break;
            if (cyc >= 300) begin
                chk("run_cycle_bound", fin[0] * 4 + fin[1], 10);
                break;
            end
            ch_done = seq[cyc];
            start   = (cyc == mid_start);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic rst_run();
        start          = 1'b1;
        ch_mask        = 4'hF;
        timeout_cycles = 8'd0;
        ch_done        = 4'h0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            chk("rst_pre_busy1", busy1, 1);
            chk("rst_pre_busy4", busy4, 1);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        ch_done = 4'hF;
        chk("rst_flags1", {busy1, done1, to1, pass1}, 0);
        chk("rst_status1", st1, 0);
        chk("rst_elapsed1", el1, 0);
        chk("rst_flags4", {busy4, done4, to4, pass4}, 0);
        chk("rst_status4", st4, 0);
        chk("rst_elapsed4", el4, 0);
        repeat (4) begin
            @(posedge clk); #1;
            chk("rst_quiet1", {busy1, done1, to1}, 0);
            chk("rst_quiet4", {busy4, done4, to4}, 0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        ch_mask        = 4'h0;
        ch_done        = 4'h0;
        timeout_cycles = 8'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags1", {busy1, done1, to1, pass1}, 0);
        chk("reset_status1", st1, 0);
        chk("reset_elapsed1", el1, 0);
        chk("reset_flags4", {busy4, done4, to4, pass4}, 0);
        chk("reset_status4", st4, 0);
        chk("reset_elapsed4", el4, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Channels rising one by one, all high from WAIT cycle 10, no timeout.
        for (int c = 0; c < 400; c++)
            seq[c] = (c < 3) ? 4'h0 : (c < 6) ? 4'h1 : (c < 8) ? 4'h3 : (c < 10) ? 4'h7 : 4'hF;
        run(4'hF, 0, -1);

        // One channel never completes: timeout after 20 cycles.
        for (int c = 0; c < 400; c++) seq[c] = 4'h7;
        run(4'hF, 20, -1);

        // One-cycle pulse on bit 0, bit 2 held later: sticky-dependent outcome.
        for (int c = 0; c < 400; c++)
            seq[c] = (c == 3) ? 4'h1 : (c >= 6) ? 4'h4 : 4'h0;
        run(4'h5, 15, -1);

        // Empty mask with a start pulse ignored during WAIT.
        for (int c = 0; c < 400; c++) seq[c] = 4'($urandom);
        run(4'h0, 50, 0);

        // Completion on the same cycle the timeout would fire.
        for (int c = 0; c < 400; c++) seq[c] = (c >= 11) ? 4'hF : 4'h0;
        run(4'hF, 12, -1);

        // All done from cycle 1: polling divider delays the done.
        for (int c = 0; c < 400; c++) seq[c] = (c >= 1) ? 4'hF : 4'h0;
        run(4'hF, 0, -1);

        rst_run();

        repeat (20) begin
            logic [3:0] m;
            int         t;
            m = 4'($urandom);
            t = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 60));
            for (int c = 0; c < 400; c++)
                seq[c] = (c >= 100) ? 4'hF : (4'($urandom) | 4'($urandom));
            run(m, t, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_done_aggregator.md
RF_DONE_AGGREGATOR -- requirements
Module: rf_done_aggregator

Interface
REQ-001 SHALL have parameter NUM_CH, default 11: number of completion channels (1..32).
REQ-002 SHALL have parameter TIMEOUT_W, default 20: width of the timeout and elapsed counters.
REQ-003 SHALL have parameter POLL_DIV, default 1: evaluate the done condition every POLL_DIV cycles (1..256).
REQ-004 SHALL have port clk  in  1: the single clock.
REQ-005 SHALL have port rst  in  1: synchronous reset on clk, active-high.
REQ-006 SHALL have port start  in  1: one-cycle request that begins a wait sequence.
REQ-007 SHALL have port ch_mask  in  NUM_CH: 1 means the channel participates; sampled on accepted start.
REQ-008 SHALL have port ch_done  in  NUM_CH: per-channel completion level flags.
REQ-009 SHALL have port timeout_cycles  in  TIMEOUT_W: wait limit, sampled on accepted start; 0 means no timeout.
REQ-010 SHALL have port busy  out  1: high in WAIT.
REQ-011 SHALL have port done  out  1: one-cycle pulse when all masked channels are complete.
REQ-012 SHALL have port timed_out  out  1: one-cycle pulse on timeout.
REQ-013 SHALL have port pass  out  1: level, set with done, cleared by the next accepted start or by rst.
REQ-014 SHALL have port ch_status  out  NUM_CH: per-channel completion captured at the done or timeout event.
REQ-015 SHALL have port elapsed  out  TIMEOUT_W: WAIT cycle count, held after completion.

Function
REQ-016 SHALL implement states IDLE, WAIT, FIN_OK and FIN_TO; FIN_OK and FIN_TO last exactly one cycle, then return to IDLE.
REQ-017 SHALL accept start only in IDLE, moving to WAIT on the next edge; start in any other state is ignored.
REQ-018 SHALL, on accepted start, latch ch_mask and timeout_cycles, clear elapsed, pass, ch_status and the poll counter, and clear the completion accumulator.
REQ-019 SHALL increment elapsed once per WAIT cycle, saturating at 2^TIMEOUT_W-1.
REQ-020 SHALL increment the poll counter once per WAIT cycle, wrapping from POLL_DIV-1 to 0; the done condition is evaluated only when the poll counter equals POLL_DIV-1.
REQ-021 SHALL define the done condition as (complete & mask) == mask, where complete is ch_done or the sticky accumulator (see Configuration).
REQ-022 SHALL, when the done condition holds at an evaluation, enter FIN_OK: done=1 and pass=1 during FIN_OK, with ch_status = complete.
REQ-023 SHALL enter FIN_TO (timed_out=1, ch_status = complete, pass=0) when the latched timeout is non-zero, elapsed+1 >= timeout, and the done condition does not also hold in that cycle.
REQ-024 SHALL let done win over timeout when both occur in the same cycle.
REQ-025 SHALL have a latency, with POLL_DIV=1, of one cycle from start high to busy high, and one cycle from the sampled all-done condition to done high.
REQ-026 SHALL, with a latched mask of all zeros, enter FIN_OK at the first evaluation.
REQ-027 SHALL, with a latched timeout of 0, wait indefinitely.

Reset
REQ-028 SHALL, on rst, go to IDLE and drive busy, done, timed_out and pass to 0, ch_status to 0 and elapsed to 0, with the latched mask, timeout and accumulator cleared.
REQ-029 SHALL, on rst asserted mid-WAIT, abort without emitting done or timed_out.

Configuration
REQ-030 SHALL, when macro RF_DONE_AGG_STICKY_EN is defined, OR ch_done into a per-channel sticky accumulator every WAIT cycle and use the accumulator as complete, so any one-cycle ch_done pulse counts.
REQ-031 SHALL, when RF_DONE_AGG_STICKY_EN is undefined, use the live ch_done as complete, so all masked channels must be high in the same evaluation cycle; no accumulator registers are built.

Verification (NUM_CH=4, TIMEOUT_W=8, POLL_DIV=1 unless stated)
REQ-032 SHALL cover: mask=4'hF, timeout=0, ch_done rising bit-by-bit and all high at cycle 10 of WAIT -> done pulse at cycle 11, pass=1, ch_status=4'hF, elapsed=11.
REQ-033 SHALL cover: mask=4'hF, timeout=20, ch_done=4'h7 constant -> timed_out pulse after 20 WAIT cycles, pass=0, ch_status=4'h7, elapsed=20.
REQ-034 SHALL cover: mask=4'h5, ch_done bit0 pulsed for 1 cycle at cycle 3, bit2 held from cycle 6 -> STICKY_EN: done at cycle 7, ch_status=4'h5; not STICKY_EN: no done, and timed_out at timeout=15.
REQ-035 SHALL cover: mask=4'h0 -> done one cycle after busy rises; a start pulse during WAIT leaves elapsed uninterrupted.
REQ-036 SHALL cover: all-done condition reached on the same cycle elapsed+1 == timeout=12 -> done=1 and timed_out=0.
REQ-037 SHALL cover: POLL_DIV=4 with all-done from cycle 1 -> done after the first evaluation at cycle 4; then rst mid-WAIT in a second run -> all outputs 0 next cycle and no pulses.
